// File: rtl/uart_rx_os4.sv
// uart_rx_os4: oversampling UART receiver (8N1 by default) clocked from i_CLK_50M.
// i_BAUD_CLK runs at OVERSAMPLE x baud and is synchronised and edge-detected
// into a one-cycle tick. All frame state advances only on tick cycles.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the
// data and stop bits, plus the o_PARITY_ERR strobe.
//
// Handshake: o_VALID is a one-cycle strobe with no ready/backpressure. o_DATA
// is new in the cycle o_VALID is high and holds until the next good frame.
// o_FRAME_ERR and o_PARITY_ERR are one-cycle strobes. They never coincide with
// o_VALID.
`timescale 1ns/1ps
module uart_rx_os4 #(
   parameter int OVERSAMPLE = 4,
   parameter int DATA_BITS  = 8
) (
   input  logic                 i_CLK_50M,
   input  logic                 RST,
   input  logic                 i_BAUD_CLK,
   input  logic                 i_RXD,
   output logic [DATA_BITS-1:0] o_DATA,
   output logic                 o_VALID,
   output logic                 o_FRAME_ERR,
`ifdef UART_RX_PARITY_EN
   output logic                 o_PARITY_ERR,
`endif
   output logic                 o_BUSY
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   // The start bit is confirmed one tick before the counter would reach
   // OVERSAMPLE/2-1. That puts the stop sample (OVERSAMPLE/2-1) +
   // OVERSAMPLE*(DATA_BITS+1) ticks after start detect.
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 2);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t                 state, state_n;
   logic [TW-1:0]          tcnt, tcnt_n;
   logic [BW-1:0]          bcnt, bcnt_n;
   logic [DATA_BITS-1:0]   shreg, shreg_n;
   logic [DATA_BITS-1:0]   data_n;
   logic                   valid_n, ferr_n;
   logic                   rxd_m, rxd_s;
   logic                   bclk_m, bclk_s, bclk_d, edge_r, tick;
`ifdef UART_RX_PARITY_EN
   logic                   par_r, par_n, perr_n;
`endif

   // Synchronise both async inputs and register a one-cycle tick per baud-clock rise.
   always_ff @(posedge i_CLK_50M) begin
      if (RST) begin
         rxd_m  <= 1'b1;
         rxd_s  <= 1'b1;
         bclk_m <= 1'b0;
         bclk_s <= 1'b0;
         bclk_d <= 1'b0;
         edge_r <= 1'b0;
         tick   <= 1'b0;
      end else begin
         rxd_m  <= i_RXD;
         rxd_s  <= rxd_m;
         bclk_m <= i_BAUD_CLK;
         bclk_s <= bclk_m;
         bclk_d <= bclk_s;
         edge_r <= bclk_s & ~bclk_d;
         tick   <= edge_r;
      end
   end

   // Frame state, counters, shift register and registered output strobes.
   always_ff @(posedge i_CLK_50M) begin
      if (RST) begin
         state        <= S_IDLE;
         tcnt         <= '0;
         bcnt         <= '0;
         shreg        <= '0;
         o_DATA       <= '0;
         o_VALID      <= 1'b0;
         o_FRAME_ERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r        <= 1'b0;
         o_PARITY_ERR <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         tcnt         <= tcnt_n;
         bcnt         <= bcnt_n;
         shreg        <= shreg_n;
         o_DATA       <= data_n;
         o_VALID      <= valid_n;
         o_FRAME_ERR  <= ferr_n;
`ifdef UART_RX_PARITY_EN
         par_r        <= par_n;
         o_PARITY_ERR <= perr_n;
`endif
      end
   end

   // Next-state and next-output decode. Nothing moves unless tick is high.
   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      data_n  = o_DATA;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n   = par_r;
      perr_n  = 1'b0;
`endif
      if (tick) begin
         case (state)
            S_IDLE: begin
               if (!rxd_s) begin
                  state_n = S_START;
                  tcnt_n  = '0;
               end
            end
            S_START: begin
               if (tcnt == T_MID) begin
                  if (rxd_s) begin
                     // Line went high again before mid-bit: treat it as a glitch.
                     state_n = S_IDLE;
                     tcnt_n  = '0;
                  end else begin
                     state_n = S_DATA;
                     tcnt_n  = '0;
                     bcnt_n  = '0;
                  end
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            S_DATA: begin
               if (tcnt == T_LAST) begin
                  shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                  tcnt_n  = '0;
                  if (bcnt == B_LAST) begin
                     bcnt_n  = '0;
`ifdef UART_RX_PARITY_EN
                     state_n = S_PARITY;
`else
                     state_n = S_STOP;
`endif
                  end else begin
                     bcnt_n = bcnt + 1'b1;
                  end
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tcnt == T_LAST) begin
                  par_n   = rxd_s;
                  tcnt_n  = '0;
                  state_n = S_STOP;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (tcnt == T_LAST) begin
                  tcnt_n = '0;
                  if (rxd_s) begin
                     state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                     if ((^shreg) ^ par_r) begin
                        perr_n = 1'b1;
                     end else begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                     end
`else
                     data_n  = shreg;
                     valid_n = 1'b1;
`endif
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = S_BREAK;
                  end
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
            S_BREAK: begin
               // Wait out a held-low line without flagging further errors.
               if (rxd_s) begin
                  state_n = S_IDLE;
               end
            end
            default: begin
               state_n = S_IDLE;
               tcnt_n  = '0;
               bcnt_n  = '0;
            end
         endcase
      end
   end

   assign o_BUSY = (state != S_IDLE);

endmodule
